// File: rtl/multi_port_sw_interface.sv
// Avalon-MM register block between the HPS and an N-port switch datapath.
// It provides a TX strobe per port, a buffered RX FIFO per port, and status, error and capability registers.
module multi_port_sw_interface #(
   parameter int N_PORTS      = 4,
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR_W       = 3,
   parameter int DROP_ON_FULL = 0
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        chipselect,
   input  logic                        write,
   input  logic                        read,
   input  logic [ADDR_W-1:0]           address,
   input  logic [DATA_W-1:0]           writedata,
   output logic [DATA_W-1:0]           readdata,
   input  logic [N_PORTS*DATA_W-1:0]   egress_data,
   input  logic [N_PORTS-1:0]          egress_valid,
   output logic [N_PORTS-1:0]          egress_ready,
   output logic [DATA_W-1:0]           tx_data,
   output logic [N_PORTS-1:0]          tx_en,
   output logic                        experimenting,
   output logic                        send_only,
   output logic                        simple_reset
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [31:0] CAPS = {8'(N_PORTS), 8'(FIFO_DEPTH), 16'h0};

   logic [1:0]              r_mode;
   logic                    r_prevRead;
   logic [2*N_PORTS-1:0]    r_err;
   logic [DATA_W-1:0]       r_mem  [N_PORTS][FIFO_DEPTH];
   logic [PW:0]             r_wptr [N_PORTS];
   logic [PW:0]             r_rptr [N_PORTS];

   logic                    w_run;
   logic                    w_wrAcc;
   logic                    w_rdEdge;
   logic [N_PORTS-1:0]      w_sel;
   logic [N_PORTS-1:0]      w_empty;
   logic [N_PORTS-1:0]      w_full;
   logic [N_PORTS-1:0]      w_push;
   logic [N_PORTS-1:0]      w_pop;
   logic [N_PORTS-1:0]      w_ovf;
   logic [N_PORTS-1:0]      w_udf;
   logic [2*N_PORTS-1:0]    w_errClr;
   logic [DATA_W-1:0]       w_rdMux;

   // Ready never looks ahead at a same-cycle pop; only drop mode lets a pop make room for a push.
   always_comb begin
      w_run    = (r_mode != 2'd0);
      w_wrAcc  = chipselect & write;
      w_rdEdge = chipselect & read & ~r_prevRead;
      w_sel        = '0;
      w_empty      = '0;
      w_full       = '0;
      w_push       = '0;
      w_pop        = '0;
      w_ovf        = '0;
      w_udf        = '0;
      egress_ready = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         w_sel[p]   = (address == ADDR_W'(4 + p));
         w_empty[p] = (r_wptr[p] == r_rptr[p]);
         w_full[p]  = (r_wptr[p][PW] != r_rptr[p][PW]) &&
                      (r_wptr[p][PW-1:0] == r_rptr[p][PW-1:0]);
         w_pop[p]   = w_rdEdge & w_sel[p] & ~w_empty[p];
         w_udf[p]   = w_rdEdge & w_sel[p] & w_empty[p];
         if (DROP_ON_FULL != 0) begin
            egress_ready[p] = w_run;
            w_push[p]       = egress_valid[p] & w_run & (~w_full[p] | w_pop[p]);
            w_ovf[p]        = egress_valid[p] & w_run & w_full[p] & ~w_pop[p];
         end else begin
            egress_ready[p] = w_run & ~w_full[p];
            w_push[p]       = egress_valid[p] & egress_ready[p];
         end
      end
      w_errClr = (w_wrAcc && address == ADDR_W'(2)) ? writedata[2*N_PORTS-1:0] : '0;
   end

   always_comb begin
      w_rdMux = '0;
      case (address)
         ADDR_W'(0): w_rdMux = DATA_W'(r_mode);
         ADDR_W'(1): w_rdMux = DATA_W'({w_full, ~w_empty});
         ADDR_W'(2): w_rdMux = DATA_W'(r_err);
         ADDR_W'(3): w_rdMux = DATA_W'(CAPS);
         default: begin
            for (int p = 0; p < N_PORTS; p++) begin
               if (w_sel[p] && !w_empty[p]) begin
                  w_rdMux = r_mem[p][r_rptr[p][PW-1:0]];
               end
            end
         end
      endcase
   end

   // An error set in the same cycle as a write-1-to-clear survives the clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode     <= 2'd0;
         r_prevRead <= 1'b0;
         r_err      <= '0;
         readdata   <= '0;
         tx_data    <= '0;
         tx_en      <= '0;
      end else begin
         r_prevRead <= chipselect & read;
         tx_en      <= '0;
         if (w_wrAcc && address == ADDR_W'(0)) begin
            r_mode <= writedata[1:0];
         end
         if (w_wrAcc && w_run) begin
            for (int p = 0; p < N_PORTS; p++) begin
               if (w_sel[p]) begin
                  tx_en[p] <= 1'b1;
                  tx_data  <= writedata;
               end
            end
         end
         if (w_rdEdge) begin
            readdata <= w_rdMux;
         end
         r_err <= (r_err & ~w_errClr) | {w_udf, w_ovf};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < N_PORTS; p++) begin
            r_wptr[p] <= '0;
            r_rptr[p] <= '0;
         end
      end else begin
         for (int p = 0; p < N_PORTS; p++) begin
            if (!w_run) begin
               r_wptr[p] <= '0;
               r_rptr[p] <= '0;
            end else begin
               if (w_push[p]) r_wptr[p] <= r_wptr[p] + (PW+1)'(1);
               if (w_pop[p])  r_rptr[p] <= r_rptr[p] + (PW+1)'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < N_PORTS; p++) begin
         if (w_push[p]) begin
            r_mem[p][r_wptr[p][PW-1:0]] <= egress_data[p*DATA_W +: DATA_W];
         end
      end
   end

   assign experimenting = (r_mode == 2'd2);
   assign send_only     = r_mode[0];
   assign simple_reset  = (r_mode == 2'd0) | ~reset_n;

endmodule

// File: tb/tb_multi_port_sw_interface.sv
// Randomised scoreboard bench for multi_port_sw_interface.
// It runs two instances side by side, one with DROP_ON_FULL=0 and one with DROP_ON_FULL=1.
module tb_multi_port_sw_interface;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          chipselect;
   logic          write;
   logic          read;
   logic [2:0]    address;
   logic [31:0]   writedata;
   logic [127:0]  egress_data;
   logic [3:0]    egress_valid;

   logic [31:0]   readdata      [2];
   logic [31:0]   tx_data       [2];
   logic [3:0]    egress_ready  [2];
   logic [3:0]    tx_en         [2];
   logic          experimenting [2];
   logic          send_only     [2];
   logic          simple_reset  [2];

   multi_port_sw_interface #(
      .N_PORTS(4), .DATA_W(32), .FIFO_DEPTH(8), .ADDR_W(3), .DROP_ON_FULL(0)
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
      .read(read), .address(address), .writedata(writedata),
      .readdata(readdata[0]), .egress_data(egress_data),
      .egress_valid(egress_valid), .egress_ready(egress_ready[0]),
      .tx_data(tx_data[0]), .tx_en(tx_en[0]),
      .experimenting(experimenting[0]), .send_only(send_only[0]),
      .simple_reset(simple_reset[0])
   );

   multi_port_sw_interface #(
      .N_PORTS(4), .DATA_W(32), .FIFO_DEPTH(8), .ADDR_W(3), .DROP_ON_FULL(1)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
      .read(read), .address(address), .writedata(writedata),
      .readdata(readdata[1]), .egress_data(egress_data),
      .egress_valid(egress_valid), .egress_ready(egress_ready[1]),
      .tx_data(tx_data[1]), .tx_en(tx_en[1]),
      .experimenting(experimenting[1]), .send_only(send_only[1]),
      .simple_reset(simple_reset[1])
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: mode, previous read level, sticky errors, per-port word queues.
   logic [1:0]   mMode;
   logic         mPrev;
   logic [7:0]   mErr [2];
   logic [31:0]  mQ   [8][$];
   logic [31:0]  rdQ  [2][$];
   logic [35:0]  txQ  [2][$];
   logic [31:0]  lastRd [2];
   logic         monOn;
   logic [31:0]  monRd;
   logic [35:0]  monTx;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: whenever a response is due, pop the scoreboard and compare.
   always @(negedge clk) begin
      if (monOn) begin
         for (int d = 0; d < 2; d++) begin
            if (rdQ[d].size() > 0) begin
               monRd = rdQ[d].pop_front();
               checkOutput($sformatf("readdata[%0d]", d), 64'(readdata[d]), 64'(monRd));
               lastRd[d] = monRd;
            end else begin
               checkOutput($sformatf("readdata_hold[%0d]", d), 64'(readdata[d]), 64'(lastRd[d]));
            end
            if (txQ[d].size() > 0) begin
               monTx = txQ[d].pop_front();
               checkOutput($sformatf("tx_en[%0d]", d), 64'(tx_en[d]), 64'(monTx[35:32]));
               checkOutput($sformatf("tx_data[%0d]", d), 64'(tx_data[d]), 64'(monTx[31:0]));
            end else begin
               checkOutput($sformatf("tx_en_idle[%0d]", d), 64'(tx_en[d]), 64'd0);
            end
         end
      end
   end

   task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                                input logic [2:0] addr, input logic [31:0] wd,
                                input logic [3:0] ev, input logic [127:0] ed);
      logic        rdEdge;
      logic        txHit;
      logic [31:0] rdExp [2];
      logic [7:0]  setBits;
      logic [7:0]  clrBits;
      logic [3:0]  expReady;
      logic        pop;
      logic        push;
      logic        full;
      logic [31:0] word;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         expReady = 4'h0;
         for (int p = 0; p < 4; p++) begin
            if (mMode != 2'd0) expReady[p] = (d == 1) || (mQ[d*4+p].size() < 8);
         end
         checkOutput($sformatf("ready_modes[%0d]", d),
                     64'({egress_ready[d], experimenting[d], send_only[d], simple_reset[d]}),
                     64'({expReady, mMode == 2'd2, (mMode == 2'd1) || (mMode == 2'd3), mMode == 2'd0}));
      end
      chipselect   = cs;
      write        = wr;
      read         = rd;
      address      = addr;
      writedata    = wd;
      egress_valid = ev;
      egress_data  = ed;

      rdEdge = cs && rd && !mPrev;
      txHit  = cs && wr && (mMode != 2'd0) && (addr >= 3'd4);
      for (int d = 0; d < 2; d++) begin
         setBits  = 8'h0;
         clrBits  = (cs && wr && addr == 3'd2) ? wd[7:0] : 8'h0;
         rdExp[d] = 32'h0;
         if (rdEdge) begin
            case (addr)
               3'd0: rdExp[d] = 32'(mMode);
               3'd1: for (int p = 0; p < 4; p++) begin
                        rdExp[d][p]   = mQ[d*4+p].size() > 0;
                        rdExp[d][4+p] = mQ[d*4+p].size() == 8;
                     end
               3'd2: rdExp[d] = 32'(mErr[d]);
               3'd3: rdExp[d] = 32'h0408_0000;
               default: begin
                  if (mQ[d*4 + int'(addr) - 4].size() > 0) rdExp[d] = mQ[d*4 + int'(addr) - 4][0];
                  else setBits[int'(addr)] = 1'b1;
               end
            endcase
         end
         for (int p = 0; p < 4; p++) begin
            if (mMode == 2'd0) begin
               mQ[d*4+p].delete();
            end else begin
               pop  = rdEdge && (addr == 3'(4 + p)) && (mQ[d*4+p].size() > 0);
               full = (mQ[d*4+p].size() == 8);
               push = ev[p] && ((d == 1) ? (!full || pop) : !full);
               if ((d == 1) && ev[p] && full && !pop) setBits[p] = 1'b1;
               if (pop) word = mQ[d*4+p].pop_front();
               if (push) mQ[d*4+p].push_back(ed[p*32 +: 32]);
            end
         end
         mErr[d] = (mErr[d] & ~clrBits) | setBits;
      end
      if (cs && wr && addr == 3'd0) mMode = wd[1:0];
      mPrev = cs && rd;

      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rdEdge) rdQ[d].push_back(rdExp[d]);
         if (txHit)  txQ[d].push_back({4'b0001 << (addr - 3'd4), wd});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 128'h0);
   endtask

   task automatic wrReg(input logic [2:0] a, input logic [31:0] d);
      applyStimulus(1'b1, 1'b1, 1'b0, a, d, 4'h0, 128'h0);
   endtask

   task automatic rdReg(input logic [2:0] a);
      applyStimulus(1'b1, 1'b0, 1'b1, a, 32'h0, 4'h0, 128'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, a, 32'h0, 4'h0, 128'h0);
   endtask

   task automatic pushWord(input int p, input logic [31:0] w);
      logic [127:0] ed;
      ed = 128'h0;
      ed[p*32 +: 32] = w;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'(1 << p), ed);
   endtask

   initial begin
      logic [127:0] ed;
      logic [3:0]   ev;
      logic [2:0]   a;
      logic [31:0]  wd;
      int           r;

      reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = 3'd0; writedata = 32'h0; egress_valid = 4'h0; egress_data = 128'h0;
      mMode = 2'd0; mPrev = 1'b0; monOn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         mErr[d] = 8'h0;
         lastRd[d] = 32'h0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("reset_outputs[%0d]", d),
                     64'({readdata[d], tx_en[d], egress_ready[d]}), 64'h0);
         checkOutput($sformatf("reset_txdata[%0d]", d), 64'(tx_data[d]), 64'h0);
         checkOutput($sformatf("reset_modes[%0d]", d),
                     64'({experimenting[d], send_only[d], simple_reset[d]}), 64'b001);
      end
      reset_n = 1'b1;
      monOn   = 1'b1;

      $display("[TB] caps / status after reset");
      rdReg(3'd3);
      rdReg(3'd1);

      $display("[TB] experimenting mode and TX strobe");
      wrReg(3'd0, 32'd2);
      wrReg(3'd6, 32'hDEAD_BEEF);
      wrReg(3'd4, 32'h1234_5678);
      wrReg(3'd7, 32'hCAFE_F00D);
      idle(2);

      $display("[TB] three words through port 1");
      pushWord(1, 32'h11);
      pushWord(1, 32'h22);
      pushWord(1, 32'h33);
      rdReg(3'd1);
      repeat (3) rdReg(3'd5);
      rdReg(3'd1);

      $display("[TB] fill port 0 and overflow");
      for (int i = 0; i < 8; i++) pushWord(0, 32'hA000_0000 + 32'(i));
      for (int i = 0; i < 3; i++) pushWord(0, 32'hBAD0_0000 + 32'(i));
      rdReg(3'd1);
      rdReg(3'd2);
      wrReg(3'd2, 32'h1);
      rdReg(3'd2);

      $display("[TB] underflow on port 3 and held read");
      rdReg(3'd7);
      rdReg(3'd2);
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, 3'd4, 32'h0, 4'h0, 128'h0);
      idle(1);
      rdReg(3'd1);
      rdReg(3'd4);

      $display("[TB] simultaneous push and pop on port 2");
      for (int i = 0; i < 4; i++) pushWord(2, 32'hC000_0000 + 32'(i));
      ed = 128'h0;
      ed[64 +: 32] = 32'hC000_00FF;
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd6, 32'h0, 4'b0100, ed);
      idle(1);
      repeat (5) rdReg(3'd6);
      rdReg(3'd2);

      $display("[TB] mode 3 and randomised traffic");
      wrReg(3'd0, 32'd3);
      wrReg(3'd5, 32'h5555_AAAA);
      for (int i = 0; i < 1500; i++) begin
         ed = {$urandom, $urandom, $urandom, $urandom};
         ev = (i < 750) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
         r  = $urandom_range(0, 9);
         a  = 3'($urandom_range(0, 7));
         wd = $urandom;
         if (r < 4) begin
            applyStimulus(1'b1, 1'b0, 1'b1, a, 32'h0, ev, ed);
         end else if (r < 6) begin
            if (a == 3'd0) begin
               wd = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 3));
            end
            applyStimulus(1'b1, 1'b1, 1'b0, a, wd, ev, ed);
         end else begin
            applyStimulus(1'b0, 1'b0, 1'b0, a, 32'h0, ev, ed);
         end
      end

      $display("[TB] flush by mode 0 during traffic");
      wrReg(3'd0, 32'd1);
      for (int i = 0; i < 6; i++) pushWord(i % 4, $urandom);
      wrReg(3'd0, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'hF, {$urandom, $urandom, $urandom, $urandom});
      idle(1);
      rdReg(3'd1);
      rdReg(3'd2);
      wrReg(3'd6, 32'h0BAD_0BAD);
      idle(3);

      checkOutput("scoreboard_drained",
                  64'(rdQ[0].size() + rdQ[1].size() + txQ[0].size() + txQ[1].size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
